// File: rtl/exe_alu_stage.sv
// Execute stage: ALU and two-step multiply with registered result, forwarded
// control, the {N,Z,C,V} status register, and freeze/flush pipeline handling.
module exe_alu_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             wb_en_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             status_update,
  input  logic [3:0]       dest_in,
  output logic [WIDTH-1:0] alu_result,
  output logic             wb_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       dest,
  output logic [3:0]       status,
  output logic             mul_pending
);

  typedef enum logic [3:0] {
    CMD_MOV  = 4'b0001,
    CMD_ADD  = 4'b0010,
    CMD_ADC  = 4'b0011,
    CMD_SUB  = 4'b0100,
    CMD_SBC  = 4'b0101,
    CMD_AND  = 4'b0110,
    CMD_ORR  = 4'b0111,
    CMD_EOR  = 4'b1000,
    CMD_MVN  = 4'b1001,
    CMD_MUL1 = 4'b1100,
    CMD_MUL2 = 4'b1101
  } cmd_e;

  cmd_e                 cmd;
  logic [WIDTH-1:0]     mul_hi;
  logic [WIDTH-1:0]     res;
  logic [WIDTH-1:0]     addend;
  logic                 cin;
  logic                 is_arith;
  logic                 is_nz_only;
  logic [WIDTH:0]       sum;
  logic                 ovf;
  logic [2*WIDTH-1:0]   product;
  logic [3:0]           next_status;

  assign cmd = cmd_e'(exe_cmd);

  // Subtraction is val1 + ~val2 + carry-in, so one adder gives result, carry
  // (1 = no borrow) and overflow for all four arithmetic commands.
  assign sum     = {1'b0, val1} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
  assign ovf     = (val1[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
  assign product = {{WIDTH{1'b0}}, val1} * {{WIDTH{1'b0}}, val2};

  always_comb begin
    res        = '0;
    addend     = val2;
    cin        = 1'b0;
    is_arith   = 1'b0;
    is_nz_only = 1'b0;
    case (cmd)
      CMD_MOV: begin
        res        = val2;
        is_nz_only = 1'b1;
      end
      CMD_MVN: begin
        res        = ~val2;
        is_nz_only = 1'b1;
      end
      CMD_ADD: begin
        res      = sum[WIDTH-1:0];
        is_arith = 1'b1;
      end
      CMD_ADC: begin
        cin      = status[1];
        res      = sum[WIDTH-1:0];
        is_arith = 1'b1;
      end
      CMD_SUB: begin
        addend   = ~val2;
        cin      = 1'b1;
        res      = sum[WIDTH-1:0];
        is_arith = 1'b1;
      end
      CMD_SBC: begin
        addend   = ~val2;
        cin      = status[1];
        res      = sum[WIDTH-1:0];
        is_arith = 1'b1;
      end
      CMD_AND: begin
        res        = val1 & val2;
        is_nz_only = 1'b1;
      end
      CMD_ORR: begin
        res        = val1 | val2;
        is_nz_only = 1'b1;
      end
      CMD_EOR: begin
        res        = val1 ^ val2;
        is_nz_only = 1'b1;
      end
      CMD_MUL1: begin
        res        = product[WIDTH-1:0];
        is_nz_only = 1'b1;
      end
      CMD_MUL2: begin
        res        = mul_hi;
        is_nz_only = 1'b1;
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    next_status = status;
    if (is_arith) begin
      next_status = {res[WIDTH-1], (res == '0), sum[WIDTH], ovf};
    end else if (is_nz_only) begin
      next_status = {res[WIDTH-1], (res == '0), status[1], status[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result  <= '0;
      wb_en       <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      dest        <= '0;
      status      <= '0;
      mul_hi      <= '0;
      mul_pending <= 1'b0;
    end else if (!freeze) begin
      if (flush) begin
        alu_result  <= '0;
        wb_en       <= 1'b0;
        mem_read    <= 1'b0;
        mem_write   <= 1'b0;
        dest        <= '0;
        mul_pending <= 1'b0;
      end else begin
        alu_result <= res;
        wb_en      <= wb_en_in;
        mem_read   <= mem_read_in;
        mem_write  <= mem_write_in;
        dest       <= dest_in;
        if (status_update) status <= next_status;
        if (cmd == CMD_MUL1) begin
          mul_hi      <= product[2*WIDTH-1:WIDTH];
          mul_pending <= 1'b1;
        end else if (cmd == CMD_MUL2) begin
          mul_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_alu_stage.sv
// Bench for exe_alu_stage: directed corner cases then randomized traffic,
// compared against an arithmetic reference model of the execute stage.
module tb_exe_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  exe_cmd = '0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic        wb_en_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        status_update = 1'b0;
  logic [3:0]  dest_in = '0;
  logic [31:0] alu_result;
  logic        wb_en;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  dest;
  logic [3:0]  status;
  logic        mul_pending;

  exe_alu_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .exe_cmd      (exe_cmd),
    .val1         (val1),
    .val2         (val2),
    .wb_en_in     (wb_en_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .status_update(status_update),
    .dest_in      (dest_in),
    .alu_result   (alu_result),
    .wb_en        (wb_en),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .dest         (dest),
    .status       (status),
    .mul_pending  (mul_pending)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_res, m_hi;
  logic [3:0]  m_status, m_dest;
  logic        m_wb, m_mr, m_mw, m_pend;

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".alu_result"}, {32'b0, alu_result}, {32'b0, m_res});
    check({ctx, ".wb_en"}, {63'b0, wb_en}, {63'b0, m_wb});
    check({ctx, ".mem_read"}, {63'b0, mem_read}, {63'b0, m_mr});
    check({ctx, ".mem_write"}, {63'b0, mem_write}, {63'b0, m_mw});
    check({ctx, ".dest"}, {60'b0, dest}, {60'b0, m_dest});
    check({ctx, ".status"}, {60'b0, status}, {60'b0, m_status});
    check({ctx, ".mul_pending"}, {63'b0, mul_pending}, {63'b0, m_pend});
  endtask

  task automatic model_reset();
    m_res = '0; m_hi = '0; m_status = '0; m_dest = '0;
    m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_pend = 1'b0;
  endtask

  // One clock edge of the execute stage, computed from the instruction rules.
  task automatic model_edge();
    logic [31:0] a, b, r;
    logic [63:0] w;
    longint      sv;
    bit          cf, vf, arith, nz, c_in;
    if (freeze) return;
    if (flush) begin
      m_res = '0; m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_dest = '0; m_pend = 1'b0;
      return;
    end
    a = val1; b = val2; c_in = m_status[1];
    r = '0; w = '0; sv = 0; cf = 1'b0; arith = 1'b0; nz = 1'b1;
    case (exe_cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h2: begin
        w = {32'b0, a} + {32'b0, b}; r = w[31:0]; cf = w[32];
        sv = sx(a) + sx(b); arith = 1'b1;
      end
      4'h3: begin
        w = {32'b0, a} + {32'b0, b} + (c_in ? 64'd1 : 64'd0); r = w[31:0]; cf = w[32];
        sv = sx(a) + sx(b) + (c_in ? 64'sd1 : 64'sd0); arith = 1'b1;
      end
      4'h4: begin
        r = a - b; cf = ({32'b0, a} >= {32'b0, b});
        sv = sx(a) - sx(b); arith = 1'b1;
      end
      4'h5: begin
        r = a - b - (c_in ? 32'd0 : 32'd1);
        cf = ({32'b0, a} >= {32'b0, b} + (c_in ? 64'd0 : 64'd1));
        sv = sx(a) - sx(b) - (c_in ? 64'sd0 : 64'sd1); arith = 1'b1;
      end
      4'hC: begin
        w = {32'b0, a} * {32'b0, b}; r = w[31:0]; m_hi = w[63:32]; m_pend = 1'b1;
      end
      4'hD: begin
        r = m_hi; m_pend = 1'b0;
      end
      default: nz = 1'b0;
    endcase
    vf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    if (status_update && (arith || nz))
      m_status = {r[31], (r == 32'd0), arith ? cf : m_status[1], arith ? vf : m_status[0]};
    m_res = r; m_wb = wb_en_in; m_mr = mem_read_in; m_mw = mem_write_in; m_dest = dest_in;
  endtask

  task automatic step(input string tag, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic su, input logic fz, input logic fl);
    exe_cmd = c; val1 = a; val2 = b; status_update = su; freeze = fz; flush = fl;
    wb_en_in = $urandom_range(0, 1); mem_read_in = $urandom_range(0, 1);
    mem_write_in = $urandom_range(0, 1); dest_in = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;

    step("add_ovf", 4'h2, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    check("add_ovf.const_res", {32'b0, alu_result}, 64'h80000000);
    check("add_ovf.const_status", {60'b0, status}, 64'h9);

    step("sub_zero", 4'h4, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    check("sub_zero.const_status", {60'b0, status}, 64'h6);
    step("adc_carry", 4'h3, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    check("adc_carry.const_res", {32'b0, alu_result}, 64'd3);
    step("sbc", 4'h5, 32'd3, 32'd7, 1'b1, 1'b0, 1'b0);
    step("sbc_noc", 4'h5, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
    step("mvn", 4'h9, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("bad_cmd", 4'hF, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0);

    step("mul1_max", 4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check("mul1_max.const_res", {32'b0, alu_result}, 64'h1);
    step("mul2_max", 4'hD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mul2_max.const_res", {32'b0, alu_result}, 64'hFFFFFFFE);
    step("mul2_idle", 4'hD, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);

    step("mul1_a", 4'hC, 32'h10000, 32'h30000, 1'b1, 1'b0, 1'b0);
    step("mul1_b", 4'hC, 32'h20000, 32'h40000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("freeze", 4'h2, 32'($urandom), 32'($urandom), 1'b1, 1'b1, 1'b1);
    step("mul2_after_freeze", 4'hD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mul2_after_freeze.const_res", {32'b0, alu_result}, 64'h8);

    step("mul1_c", 4'hC, 32'h80000000, 32'h6, 1'b0, 1'b0, 1'b0);
    step("flush", 4'h2, 32'h1, 32'h1, 1'b1, 1'b0, 1'b1);
    check("flush.const_pend", {63'b0, mul_pending}, 64'd0);
    step("mul2_after_flush", 4'hD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("mul2_after_flush.const_res", {32'b0, alu_result}, 64'h3);

    step("mul1_d", 4'hC, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #3;
    rst = 1'b1;
    step("mul2_after_reset", 4'hD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = (($urandom & 7) == 0) ? 32'hFFFFFFFF : (($urandom & 7) == 1) ? 32'h7FFFFFFF : 32'($urandom);
      rb = (($urandom & 7) == 0) ? 32'h80000000 : (($urandom & 7) == 1) ? 32'd0 : 32'($urandom);
      step("random", rc, ra, rb,
           (rc inside {4'h0, 4'hA, 4'hB, 4'hE, 4'hF}) ? 1'b0 : 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
